// File: rtl/cdc_fifo_frame_reader.sv
// Recipient-domain frame reader for the CDC FIFO. It parses the header, forwards
// the payload on a registered valid/ready stream, checks the XOR checksum and counts frames.
module cdc_fifo_frame_reader #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned MaxLen     = 256,
  parameter int unsigned CountWidth = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Fifo_Valid,
  input  logic [DataWidth-1:0]  Fifo_Data,
  output logic                  Fifo_Deq,
  output logic                  Out_Valid,
  output logic [DataWidth-1:0]  Out_Data,
  output logic                  Out_Last,
  input  logic                  Out_Ready,
  output logic                  Frame_Ok,
  output logic                  Frame_Err,
  output logic                  Busy,
  output logic [CountWidth-1:0] FrameCount,
  output logic [CountWidth-1:0] ErrCount
);

  localparam int unsigned LenWidth = 16;
  localparam logic [LenWidth-1:0] LenMax = LenWidth'(MaxLen);

  typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_CHECK} state_t;

  state_t                r_state;
  logic [LenWidth-1:0]   r_remaining;
  logic [DataWidth-1:0]  r_csum;
  logic                  r_out_valid;
  logic [DataWidth-1:0]  r_out_data;
  logic                  r_out_last;
  logic                  r_frame_ok;
  logic                  r_frame_err;
  logic [CountWidth-1:0] r_frame_cnt;
  logic [CountWidth-1:0] r_err_cnt;

  state_t                w_state_nxt;
  logic [LenWidth-1:0]   w_remaining_nxt;
  logic [DataWidth-1:0]  w_csum_nxt;
  logic                  w_out_valid_nxt;
  logic [DataWidth-1:0]  w_out_data_nxt;
  logic                  w_out_last_nxt;
  logic                  w_frame_ok_nxt;
  logic                  w_frame_err_nxt;
  logic [CountWidth-1:0] w_frame_cnt_nxt;
  logic [CountWidth-1:0] w_err_cnt_nxt;
  logic                  w_deq;
  logic                  w_load;
  logic                  w_frame_inc;
  logic                  w_err_inc;
  logic [LenWidth-1:0]   w_len;

  assign w_len = Fifo_Data[LenWidth-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_csum      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_csum      <= w_csum_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_last  <= w_out_last_nxt;
      r_frame_ok  <= w_frame_ok_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
    end
  end

  // Next-state, dequeue decision, output register and saturating counters.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_csum_nxt      = r_csum;
    w_frame_ok_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_deq           = 1'b0;
    w_load          = 1'b0;
    w_frame_inc     = 1'b0;
    w_err_inc       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (Fifo_Valid) begin
          w_deq = 1'b1;
          if ((w_len == '0) || (w_len > LenMax)) begin
            w_frame_err_nxt = 1'b1;
            w_err_inc       = 1'b1;
          end else begin
            w_remaining_nxt = w_len;
            w_csum_nxt      = '0;
            w_state_nxt     = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        w_deq = Fifo_Valid & (~r_out_valid | Out_Ready);
        if (w_deq) begin
          w_load          = 1'b1;
          w_csum_nxt      = r_csum ^ Fifo_Data;
          w_remaining_nxt = r_remaining - LenWidth'(1);
          if (r_remaining == LenWidth'(1)) w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (Fifo_Valid) begin
          w_deq       = 1'b1;
          w_frame_inc = 1'b1;
          w_state_nxt = ST_IDLE;
          if (Fifo_Data == r_csum) begin
            w_frame_ok_nxt = 1'b1;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_err_inc       = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // A load in the same cycle as an accept replaces the word for full throughput.
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_last_nxt  = r_out_last;
    if (w_load) begin
      w_out_valid_nxt = 1'b1;
      w_out_data_nxt  = Fifo_Data;
      w_out_last_nxt  = (r_remaining == LenWidth'(1));
    end else if (r_out_valid && Out_Ready) begin
      w_out_valid_nxt = 1'b0;
      w_out_last_nxt  = 1'b0;
    end

    w_frame_cnt_nxt = r_frame_cnt;
    if (w_frame_inc && (r_frame_cnt != '1)) w_frame_cnt_nxt = r_frame_cnt + CountWidth'(1);
    w_err_cnt_nxt = r_err_cnt;
    if (w_err_inc && (r_err_cnt != '1)) w_err_cnt_nxt = r_err_cnt + CountWidth'(1);
  end

  assign Fifo_Deq   = w_deq;
  assign Out_Valid  = r_out_valid;
  assign Out_Data   = r_out_data;
  assign Out_Last   = r_out_last;
  assign Frame_Ok   = r_frame_ok;
  assign Frame_Err  = r_frame_err;
  assign Busy       = (r_state != ST_IDLE);
  assign FrameCount = r_frame_cnt;
  assign ErrCount   = r_err_cnt;

endmodule

// File: tb/tb_cdc_fifo_frame_reader.sv
// Directed bench for cdc_fifo_frame_reader: a queue models the FIFO, a scoreboard
// holds the expected payload stream, and pulse/counter results are checked per scenario.
module tb_cdc_fifo_frame_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned ML = 256;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          Fifo_Valid;
  logic [DW-1:0] Fifo_Data;
  logic          Fifo_Deq;
  logic          Out_Valid;
  logic [DW-1:0] Out_Data;
  logic          Out_Last;
  logic          Out_Ready;
  logic          Frame_Ok;
  logic          Frame_Err;
  logic          Busy;
  logic [CW-1:0] FrameCount;
  logic [CW-1:0] ErrCount;

  cdc_fifo_frame_reader #(.DataWidth(DW), .MaxLen(ML), .CountWidth(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .Fifo_Valid(Fifo_Valid), .Fifo_Data(Fifo_Data), .Fifo_Deq(Fifo_Deq),
    .Out_Valid(Out_Valid), .Out_Data(Out_Data), .Out_Last(Out_Last), .Out_Ready(Out_Ready),
    .Frame_Ok(Frame_Ok), .Frame_Err(Frame_Err), .Busy(Busy),
    .FrameCount(FrameCount), .ErrCount(ErrCount)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fifo_q[$];
  exp_t          sb[$];
  int            total = 0;
  int            bad   = 0;
  int            n_ok, n_err, n_acc, n_vld;
  logic          s_deq, s_valid;
  logic [DW-1:0] s_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    n_ok = 0; n_err = 0; n_acc = 0; n_vld = 0;
  endtask

  // One clock: drive from the FIFO model, sample at negedge, retire after posedge.
  task automatic step();
    exp_t e;
    Fifo_Valid = (fifo_q.size() != 0);
    Fifo_Data  = Fifo_Valid ? fifo_q[0] : '0;
    @(negedge clk);
    s_deq = Fifo_Deq; s_valid = Out_Valid; s_data = Out_Data;
    if (rst_n) begin
      chk("deq_without_valid", 32'(Fifo_Deq & ~Fifo_Valid), 32'd0);
      chk("ok_err_exclusive", 32'(Frame_Ok & Frame_Err), 32'd0);
      if (Frame_Ok) n_ok++;
      if (Frame_Err) n_err++;
      if (Out_Valid) n_vld++;
      if (Out_Valid && Out_Ready) begin
        n_acc++;
        chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_data", Out_Data, e.d);
          chk("out_last", 32'(Out_Last), 32'(e.l));
        end
      end
    end
    @(posedge clk);
    #1;
    if (rst_n && s_deq && fifo_q.size() != 0) void'(fifo_q.pop_front());
  endtask

  task automatic do_reset();
    fifo_q.delete();
    sb.delete();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic push_frame(input int len, input logic [DW-1:0] w[], input logic corrupt);
    logic [DW-1:0] cs = '0;
    fifo_q.push_back(32'hC0DE_0000 | DW'(len));
    for (int i = 0; i < len; i++) begin
      fifo_q.push_back(w[i]);
      sb.push_back('{d: w[i], l: (i == len - 1)});
      cs ^= w[i];
    end
    fifo_q.push_back(corrupt ? (cs ^ 32'h1) : cs);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((fifo_q.size() != 0 || sb.size() != 0 || Out_Valid) && k < budget) begin
      step();
      k++;
    end
    step();
    step();
    chk("drain_fifo_empty", 32'(fifo_q.size()), 32'd0);
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] w[];
    rst_n = 1'b0; Out_Ready = 1'b1; Fifo_Valid = 1'b0; Fifo_Data = '0;
    clr_stats();
    do_reset();
    chk("rst_out_valid", 32'(Out_Valid), 32'd0);
    chk("rst_out_data", Out_Data, 32'd0);
    chk("rst_out_last", 32'(Out_Last), 32'd0);
    chk("rst_ok_err", 32'({Frame_Ok, Frame_Err}), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_counts", 32'({FrameCount, ErrCount}), 32'd0);

    // Good 3-word frame.
    clr_stats();
    w = new[3]; w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h44;
    push_frame(3, w, 1'b0);
    drain(50);
    chk("t1_words", 32'(n_acc), 32'd3);
    chk("t1_ok", 32'(n_ok), 32'd1);
    chk("t1_err", 32'(n_err), 32'd0);
    chk("t1_fcnt", 32'(FrameCount), 32'd1);
    chk("t1_ecnt", 32'(ErrCount), 32'd0);
    chk("t1_busy", 32'(Busy), 32'd0);

    // Same frame, bad checksum (0x76).
    do_reset();
    clr_stats();
    push_frame(3, w, 1'b1);
    drain(50);
    chk("t2_words", 32'(n_acc), 32'd3);
    chk("t2_ok", 32'(n_ok), 32'd0);
    chk("t2_err", 32'(n_err), 32'd1);
    chk("t2_fcnt", 32'(FrameCount), 32'd1);
    chk("t2_ecnt", 32'(ErrCount), 32'd1);

    // Bad headers: L=0 and L=MaxLen+1.
    do_reset();
    clr_stats();
    fifo_q.push_back(32'hABCD_0000);
    fifo_q.push_back(32'hABCD_0000 | DW'(ML + 1));
    drain(20);
    chk("t3_err", 32'(n_err), 32'd2);
    chk("t3_ecnt", 32'(ErrCount), 32'd2);
    chk("t3_fcnt", 32'(FrameCount), 32'd0);
    chk("t3_no_valid", 32'(n_vld), 32'd0);
    chk("t3_busy", 32'(Busy), 32'd0);

    // Backpressure: Out_Ready low for 5 cycles after the first word.
    clr_stats();
    Out_Ready = 1'b0;
    w = new[4]; w[0] = 32'hA1; w[1] = 32'hB2; w[2] = 32'hC3; w[3] = 32'hD4;
    push_frame(4, w, 1'b0);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_stall_deq", 32'(s_deq), 32'd0);
      chk("t4_stall_valid", 32'(s_valid), 32'd1);
      chk("t4_stall_data", s_data, 32'hA1);
    end
    Out_Ready = 1'b1;
    drain(50);
    chk("t4_words", 32'(n_acc), 32'd4);
    chk("t4_ok", 32'(n_ok), 32'd1);
    chk("t4_fcnt", 32'(FrameCount), 32'd1);

    // Reset mid-frame after 2 of 4 payload words, then a clean L=1 frame.
    clr_stats();
    push_frame(4, w, 1'b0);
    for (int k = 0; k < 30 && n_acc < 2; k++) step();
    chk("t5_two_out", 32'(n_acc), 32'd2);
    do_reset();
    chk("t5_rst_valid", 32'(Out_Valid), 32'd0);
    chk("t5_rst_counts", 32'({FrameCount, ErrCount}), 32'd0);
    chk("t5_rst_busy", 32'(Busy), 32'd0);
    clr_stats();
    w = new[1]; w[0] = 32'h5A;
    push_frame(1, w, 1'b0);
    drain(20);
    chk("t5_words", 32'(n_acc), 32'd1);
    chk("t5_ok", 32'(n_ok), 32'd1);
    chk("t5_err", 32'(n_err), 32'd0);
    chk("t5_fcnt", 32'(FrameCount), 32'd1);
    chk("t5_ecnt", 32'(ErrCount), 32'd0);

    // ErrCount saturation with CountWidth=4.
    do_reset();
    clr_stats();
    for (int i = 0; i < 16; i++) fifo_q.push_back(32'h0000_0000);
    drain(40);
    chk("t6_ecnt_sat", 32'(ErrCount), 32'd15);
    fifo_q.push_back(32'h0000_FFFF);
    drain(10);
    chk("t6_ecnt_hold", 32'(ErrCount), 32'd15);
    chk("t6_err_pulses", 32'(n_err), 32'd17);
    chk("t6_fcnt", 32'(FrameCount), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
